xps2_kbd_ctrl: RTL and testbench

//  PS/2 keyboard receive controller for the picoVersat calculator, sitting between the ps2_clk/ps2_data pins and the core's peripheral bus.
//  - Deframes 11-bit PS/2 frames and merges E0/F0 prefixes into one key event.
//  - Queues events in a small FIFO that the firmware pops through a memory-mapped register interface.
//  - Drives irq while events are pending.

---
 rtl/xps2_kbd_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_xps2_kbd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xps2_kbd_ctrl.sv
// PS/2 keyboard receiver: deframes 11-bit frames, merges E0/F0 prefixes into
// one event, queues events in a FIFO read through a small register map.
module xps2_kbd_ctrl #(
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic f_odd_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_clk_s1, r_clk_s2, r_clk_s3;
  logic               r_dat_s1, r_dat_s2;
  logic [2:0]         r_bitcnt;
  logic [TO_W-1:0]    r_tocnt;
  logic [7:0]         r_shift;
  logic               r_par;
  logic               r_vld_p0;
  logic [7:0]         r_byte_p0;
  logic               r_ext_pend, r_brk_pend;
  logic               r_enable, r_par_chk;
  logic               r_ovf, r_ferr, r_perr;
  logic [9:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_irq;

  logic w_fall, w_timeout, w_accept, w_ferr_set, w_perr_set;
  logic w_push, w_full, w_do_push, w_wr_en, w_pop, w_ovf_set;
  logic w_wr_ctrl, w_flush, w_clr;
  logic [DATA_W-1:0] w_status;
  logic w_unused_bits;

  assign w_fall    = r_clk_s3 & ~r_clk_s2;
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tocnt == TO_W'(TIMEOUT - 1));

  // Input synchronisers; the third clock stage gives the edge detector its history
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
    if (!r_enable) begin
      w_state_nx = S_IDLE;
    end else if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_ferr_set = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nx = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
        S_PARITY: w_state_nx = S_STOP;
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (!r_dat_s2)                                w_ferr_set = 1'b1;
          else if (r_par_chk && !f_odd_ok(r_shift, r_par)) w_perr_set = 1'b1;
          else                                          w_accept   = 1'b1;
        end
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bitcnt <= '0;
      r_tocnt  <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      if (r_state == S_IDLE || w_fall) r_tocnt <= '0;
      else                             r_tocnt <= r_tocnt + TO_W'(1);
      if (r_state != S_DATA) r_bitcnt <= '0;
      else if (w_fall)       r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  // Stage p0: accepted byte, decoded against the prefix flags next cycle
  always_ff @(posedge clk) begin
    if (w_fall && r_state == S_DATA)   r_shift <= {r_dat_s2, r_shift[7:1]};
    if (w_fall && r_state == S_PARITY) r_par   <= r_dat_s2;
    if (w_accept)                      r_byte_p0 <= r_shift;
  end

  assign w_wr_ctrl = sel && we && (addr == 2'd2);
  assign w_flush   = w_wr_ctrl && data_in[4];
  assign w_clr     = w_wr_ctrl && data_in[5];
  assign w_push    = r_vld_p0 && (r_byte_p0 != 8'hE0) && (r_byte_p0 != 8'hF0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = w_push && !w_full;
  assign w_ovf_set = w_push && w_full;
  assign w_wr_en   = w_do_push && !w_flush;
  assign w_pop     = sel && !we && (addr == 2'd0) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_flush) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_vld_p0) begin
      if (r_byte_p0 == 8'hE0) r_ext_pend <= 1'b1;
      else if (r_byte_p0 == 8'hF0) r_brk_pend <= 1'b1;
      else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  // A new error in the same cycle as clr_err leaves the flag set
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_enable  <= 1'b1;
      r_par_chk <= 1'b0;
      r_ovf     <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable  <= data_in[0];
        r_par_chk <= data_in[1];
      end
      r_ovf  <= (r_ovf  & ~w_clr) | w_ovf_set;
      r_ferr <= (r_ferr & ~w_clr) | w_ferr_set;
      r_perr <= (r_perr & ~w_clr) | w_perr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= {r_ext_pend, r_brk_pend, r_byte_p0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= (r_count != '0);
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + FIFO_AW'(1);
        if (w_pop)     r_rptr <= r_rptr + FIFO_AW'(1);
        r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_pop);
      end
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[FIFO_AW:0]  = r_count;
    w_status[8]          = r_ovf;
    w_status[9]          = r_ferr;
    w_status[10]         = r_perr;
    w_status[11]         = r_enable;
    w_status[12]         = r_par_chk;
  end

  always_comb begin
    data_out = '0;
    if (sel && !we) begin
      case (addr)
        2'd0:    if (r_count != '0) data_out[10:0] = {1'b1, r_mem[r_rptr]};
        2'd1:    data_out = w_status;
        default: data_out = '0;
      endcase
    end
  end

  assign irq           = r_irq;
  assign w_unused_bits = ^{data_in[DATA_W-1:6], data_in[3:2]};

endmodule

// File: tb/tb_xps2_kbd_ctrl.sv
// Bench for xps2_kbd_ctrl: directed scenarios plus random frames, all checked
// against a queue-based event model of the keyboard controller.
module tb_xps2_kbd_ctrl;
  localparam int DATA_W  = 32;
  localparam int FIFO_AW = 3;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst, ps2_clk, ps2_data, sel, we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in, data_out;
  logic              irq;

  always #5 clk = ~clk;

  xps2_kbd_ctrl #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic m_ext, m_brk, m_ovf, m_ferr, m_perr, m_en, m_pc;
  logic [31:0] pop_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic oddp(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0; m_perr = 0; m_en = 1; m_pc = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input logic par, input logic stop);
    if (!m_en) return;
    if (!stop) m_ferr = 1;
    else if (m_pc && ((^{b, par}) != 1'b1)) m_perr = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (q.size() < 8) q.push_back(32'h400 | (32'(m_ext) << 9) | (32'(m_brk) << 8) | 32'(b));
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void m_ctrl(input logic [31:0] v);
    m_en = v[0];
    m_pc = v[1];
    if (v[4]) begin q.delete(); m_ext = 0; m_brk = 0; end
    if (v[5]) begin m_ovf = 0; m_ferr = 0; m_perr = 0; end
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[3:0] = 4'(q.size());
    s[8] = m_ovf; s[9] = m_ferr; s[10] = m_perr; s[11] = m_en; s[12] = m_pc;
    return s;
  endfunction

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); sel = 1; we = 0; addr = a;
    #1 d = data_out;
    @(negedge clk); sel = 0; addr = 0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk); sel = 1; we = 1; addr = a; data_in = v;
    @(negedge clk); sel = 0; we = 0; addr = 0; data_in = 0;
  endtask

  // Device side: data changes while ps2_clk is high, host samples on the fall
  task automatic ps2_bits(input logic [10:0] f, input int n, input int h, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (h) @(negedge clk);
      ps2_clk = 0;
      if (pop_last && i == n - 1) begin
        repeat (3) @(negedge clk);
        sel = 1; we = 0; addr = 0;
        #1 pop_val = data_out;
        @(negedge clk); sel = 0;
        repeat (h - 4) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      ps2_clk = 1;
    end
    @(negedge clk); ps2_data = 1;
  endtask

  task automatic tx(input logic [7:0] b, input logic par, input logic stop, input int h);
    ps2_bits({stop, par, b, 1'b0}, 11, h, 1'b0);
    m_frame(b, par, stop);
    repeat (6) @(negedge clk);
  endtask

  task automatic rd_data_chk(input string tag, output logic [31:0] d);
    logic [31:0] e;
    bus_rd(2'd0, d);
    e = (q.size() != 0) ? q.pop_front() : 32'h0;
    chk(tag, d, e);
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [31:0] d;
    bus_rd(2'd1, d);
    chk(tag, d, m_status());
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    bus_wr(2'd2, v);
    m_ctrl(v);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    m_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        p;
    int          r, k, h;

    rst = 0; ps2_clk = 1; ps2_data = 1; sel = 0; we = 0; addr = 0; data_in = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1;
    @(negedge clk);
    chk("idle_bus_zero", data_out, 32'h0);
    rd_stat_chk("rst_status");

    // Basic frame, parity ignored
    tx(8'h79, 1'b1, 1'b1, 8);
    chk("t1_irq", 32'(irq), 32'h1);
    rd_stat_chk("t1_status");
    rd_data_chk("t1_data", d);
    chk("t1_lit", d, 32'h479);
    repeat (2) @(negedge clk);
    chk("t1_irq_low", 32'(irq), 32'h0);
    rd_stat_chk("t1_status_empty");

    // Prefix merge
    tx(8'hE0, oddp(8'hE0), 1'b1, 8);
    tx(8'hF0, oddp(8'hF0), 1'b1, 8);
    tx(8'h75, oddp(8'h75), 1'b1, 8);
    rd_stat_chk("t2_status");
    rd_data_chk("t2_data", d);
    chk("t2_lit", d, 32'h775);

    // Parity checking
    wr_ctrl(32'h3);
    tx(8'h79, 1'b1, 1'b1, 8);
    rd_stat_chk("t3_perr");
    tx(8'h79, 1'b0, 1'b1, 8);
    rd_data_chk("t3_data", d);
    chk("t3_lit", d, 32'h479);
    wr_ctrl(32'h21);

    // Overflow
    for (int i = 1; i <= 9; i++) tx(8'(i), oddp(8'(i)), 1'b1, 6);
    rd_stat_chk("t4_full_ovf");
    for (int i = 1; i <= 8; i++) begin
      rd_data_chk($sformatf("t4_rd%0d", i), d);
      chk($sformatf("t4_lit%0d", i), d, 32'h400 + 32'(i));
    end
    wr_ctrl(32'h21);
    rd_stat_chk("t4_ovf_clr");

    // Timeout of a partial frame
    ps2_bits({3'b111, 8'h0B, 1'b0}, 5, 8, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    m_ferr = 1;
    rd_stat_chk("t5_ferr");
    tx(8'h5A, oddp(8'h5A), 1'b1, 8);
    rd_data_chk("t5_data", d);
    chk("t5_lit", d, 32'h45A);
    wr_ctrl(32'h21);

    // Pop coinciding with push
    tx(8'h11, oddp(8'h11), 1'b1, 8);
    tx(8'h22, oddp(8'h22), 1'b1, 8);
    rd_stat_chk("t6_cnt2");
    ps2_bits({1'b1, oddp(8'h33), 8'h33, 1'b0}, 11, 8, 1'b1);
    d = q.pop_front();
    chk("t6_pop_head", pop_val, d);
    m_frame(8'h33, oddp(8'h33), 1'b1);
    repeat (6) @(negedge clk);
    rd_stat_chk("t6_cnt_same");
    rd_data_chk("t6_rd_a", d);
    chk("t6_lit_a", d, 32'h422);
    rd_data_chk("t6_rd_b", d);
    chk("t6_lit_b", d, 32'h433);
    rd_data_chk("t6_empty", d);
    chk("t6_empty_lit", d, 32'h0);

    // Flush clears FIFO and pending prefix
    tx(8'h44, oddp(8'h44), 1'b1, 8);
    tx(8'hE0, oddp(8'hE0), 1'b1, 8);
    wr_ctrl(32'h11);
    rd_stat_chk("flush_status");
    tx(8'h66, oddp(8'h66), 1'b1, 8);
    rd_data_chk("flush_after", d);
    chk("flush_lit", d, 32'h466);

    // Unused addresses and disable
    bus_wr(2'd3, 32'hFFFF_FFFF);
    rd_stat_chk("addr3_wr_ignored");
    bus_rd(2'd2, d);
    chk("addr2_read", d, 32'h0);
    bus_rd(2'd3, d);
    chk("addr3_read", d, 32'h0);
    wr_ctrl(32'h0);
    tx(8'h12, oddp(8'h12), 1'b1, 8);
    rd_stat_chk("disabled_drop");
    wr_ctrl(32'h1);
    tx(8'h10, oddp(8'h10), 1'b0, 8);
    rd_stat_chk("stop_bad");

    // Random frames, reads and status polls
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wr_ctrl(32'h1 | (32'($urandom_range(0, 1)) << 1));
      end else if (r < 7) begin
        k = $urandom_range(0, 5);
        b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
        p = ($urandom_range(0, 5) == 0) ? ~oddp(b) : oddp(b);
        h = $urandom_range(4, 10);
        tx(b, p, 1'b1, h);
      end else if (r < 9) begin
        rd_data_chk($sformatf("rnd_data%0d", it), d);
      end else begin
        rd_stat_chk($sformatf("rnd_stat%0d", it));
      end
    end
    for (int i = 0; i < 9 && q.size() != 0; i++) rd_data_chk($sformatf("drain%0d", i), d);
    rd_stat_chk("rnd_final");

    // Reset in the middle of a frame with state pending
    wr_ctrl(32'h21);
    tx(8'h77, oddp(8'h77), 1'b1, 8);
    tx(8'h10, oddp(8'h10), 1'b0, 8);
    rd_stat_chk("pre_reset");
    ps2_bits({3'b111, 8'h0F, 1'b0}, 4, 8, 1'b0);
    do_reset();
    rd_stat_chk("mid_reset_status");
    chk("mid_reset_irq", 32'(irq), 32'h0);
    tx(8'h29, oddp(8'h29), 1'b1, 8);
    rd_data_chk("post_reset_data", d);
    chk("post_reset_lit", d, 32'h429);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
